// File: rtl/pipe_decoder.sv
// pipe_decoder: registered index decoder (one-hot or thermometer) behind a
// two-entry output buffer (output register plus skid register) with
// valid/ready handshakes on both sides. in_ready comes straight from a flop.
module pipe_decoder #(
    parameter int N    = 3,
    parameter int W    = 1 << N,
    parameter int MODE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] index,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] active,
    output logic         out_err
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } state_e;

    state_e       state_q, state_d;
    logic         in_ready_q, in_ready_d;
    logic [W-1:0] out_active_q, out_active_d;
    logic         out_err_q, out_err_d;
    logic [W-1:0] skid_active_q, skid_active_d;
    logic         skid_err_q, skid_err_d;

    logic [W-1:0] dec_active;
    logic         dec_err;
    logic         accept;
    logic         transfer;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign active    = out_active_q;
    assign out_err   = out_err_q;

    assign accept   = in_valid & in_ready_q;
    assign transfer = out_valid & out_ready;

    // Decode the offered index; the result is only used when it is captured.
    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise
        // paths that skip an assignment would infer a latch.
        dec_active = '0;
        dec_err    = 1'b0;
        if (int'(index) >= W) begin
            dec_err = 1'b1;
        end else begin
            for (int k = 0; k < W; k++) begin
                if (MODE == 0) begin
                    dec_active[k] = (k == int'(index));
                end else begin
                    dec_active[k] = (k <= int'(index));
                end
            end
        end
    end

    // Buffer control: decide where a new result lands and what the output shows.
    always_comb begin
        state_d       = state_q;
        out_active_d  = out_active_q;
        out_err_d     = out_err_q;
        skid_active_d = skid_active_q;
        skid_err_d    = skid_err_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    out_active_d = dec_active;
                    out_err_d    = dec_err;
                    state_d      = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && transfer) begin
                    out_active_d = dec_active;
                    out_err_d    = dec_err;
                end else if (accept) begin
                    skid_active_d = dec_active;
                    skid_err_d    = dec_err;
                    state_d       = ST_TWO;
                end else if (transfer) begin
                    // Output is driven to zero whenever nothing is held.
                    out_active_d = '0;
                    out_err_d    = 1'b0;
                    state_d      = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (transfer) begin
                    out_active_d  = skid_active_q;
                    out_err_d     = skid_err_q;
                    skid_active_d = '0;
                    skid_err_d    = 1'b0;
                    state_d       = ST_ONE;
                end
            end
            default: begin
                out_active_d  = '0;
                out_err_d     = 1'b0;
                skid_active_d = '0;
                skid_err_d    = 1'b0;
                state_d       = ST_EMPTY;
            end
        endcase
    end

    // Ready for the next cycle is known from the next state, so it can be a flop.
    always_comb begin
        in_ready_d = (state_d != ST_TWO);
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling the
        // pre-edge values, independent of statement order.
        if (!rst_n) begin
            state_q       <= ST_EMPTY;
            in_ready_q    <= 1'b1;
            out_active_q  <= '0;
            out_err_q     <= 1'b0;
            // NOTE: the skid entry is reset too, so a result held across a
            // reset can never resurface later.
            skid_active_q <= '0;
            skid_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            out_active_q  <= out_active_d;
            out_err_q     <= out_err_d;
            skid_active_q <= skid_active_d;
            skid_err_q    <= skid_err_d;
        end
    end

endmodule

// File: tb/tb_pipe_decoder.sv
// Testbench for pipe_decoder: three instances (one-hot W=8, thermometer W=8,
// one-hot W=6) share the same handshake stimulus and are compared against a
// queue-based reference model plus directed expected constants.
module tb_pipe_decoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] index;
    logic       out_ready;

    logic       rdy_a, ov_a, err_a;
    logic [7:0] act_a;
    logic       rdy_b, ov_b, err_b;
    logic [7:0] act_b;
    logic       rdy_c, ov_c, err_c;
    logic [5:0] act_c;

    int errors = 0;
    int checks = 0;

    // Reference model: indices held by the block, oldest first.
    int model_q[$];

    pipe_decoder #(.N(3), .W(8), .MODE(0)) u_dut_onehot (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
        .index(index), .out_valid(ov_a), .out_ready(out_ready),
        .active(act_a), .out_err(err_a)
    );

    pipe_decoder #(.N(3), .W(8), .MODE(1)) u_dut_thermo (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
        .index(index), .out_valid(ov_b), .out_ready(out_ready),
        .active(act_b), .out_err(err_b)
    );

    pipe_decoder #(.N(3), .W(6), .MODE(0)) u_dut_narrow (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c),
        .index(index), .out_valid(ov_c), .out_ready(out_ready),
        .active(act_c), .out_err(err_c)
    );

    logic [30:0] obs_all;
    logic [26:0] obs_data;
    assign obs_all  = {rdy_a, ov_a, act_a, err_a, rdy_b, ov_b, act_b, err_b,
                       rdy_c, ov_c, act_c, err_c};
    assign obs_data = {act_a, err_a, act_b, err_b, act_c, err_c};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pattern from the decode rules: 2^idx, or 2^(idx+1)-1, or 0 when out of range.
    function automatic logic [7:0] ref_pattern(input int mode, input int w, input int idx);
        int v;
        if (idx >= w) return 8'h00;
        v = (mode == 0) ? (1 << idx) : ((1 << (idx + 1)) - 1);
        return 8'(v);
    endfunction

    function automatic logic [30:0] model_vec();
        bit         mv;
        bit         mr;
        int         f;
        logic [7:0] pa, pb, pc;
        mv = model_q.size() > 0;
        mr = model_q.size() < 2;
        f  = mv ? model_q[0] : 0;
        pa = mv ? ref_pattern(0, 8, f) : 8'h00;
        pb = mv ? ref_pattern(1, 8, f) : 8'h00;
        pc = mv ? ref_pattern(0, 6, f) : 8'h00;
        return {mr, mv, pa, 1'b0, mr, mv, pb, 1'b0, mr, mv, pc[5:0], (mv && f >= 6)};
    endfunction

    // Drive one cycle of inputs, advance one edge, update the model, settle.
    task automatic tick(input logic v, input int idx, input logic ordy, input logic rst);
        bit acc, xfer;
        in_valid  = v;
        index     = 3'(idx);
        out_ready = ordy;
        rst_n     = rst;
        @(posedge clk);
        if (!rst) begin
            model_q.delete();
        end else begin
            acc  = v && (model_q.size() < 2);
            xfer = ordy && (model_q.size() > 0);
            if (xfer) void'(model_q.pop_front());
            if (acc) model_q.push_back(idx);
        end
        #1;
    endtask

    localparam logic [30:0] RESET_VEC = {1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0,
                                         1'b1, 1'b0, 6'h00, 1'b0};

    task automatic test_reset();
        tick(1'b0, 0, 1'b0, 1'b0);
        if (obs_all !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_state got=%b want=%b", obs_all, RESET_VEC);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] want;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, i, 1'b1, 1'b1);
            want = 8'h01 << i;
            if ({ov_a, act_a, err_a} !== {1'b1, want, 1'b0}) begin
                errors++;
                $display("FAIL stream idx=%0d got ov=%b act=%b err=%b want ov=1 act=%b err=0",
                         i, ov_a, act_a, err_a, want);
            end
            checks++;
        end
        tick(1'b0, 0, 1'b1, 1'b1);
        if (ov_a !== 1'b0 || act_a !== 8'h00) begin
            errors++;
            $display("FAIL stream_drain got ov=%b act=%b want ov=0 act=00000000", ov_a, act_a);
        end
        checks++;
    endtask

    task automatic test_thermo();
        int         idx_tab[3]  = '{5, 0, 7};
        logic [7:0] want_tab[3] = '{8'h3F, 8'h01, 8'hFF};
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, idx_tab[i], 1'b1, 1'b1);
            if ({ov_b, act_b, err_b} !== {1'b1, want_tab[i], 1'b0}) begin
                errors++;
                $display("FAIL thermo idx=%0d got ov=%b act=%b err=%b want ov=1 act=%b err=0",
                         idx_tab[i], ov_b, act_b, err_b, want_tab[i]);
            end
            checks++;
        end
        tick(1'b0, 0, 1'b1, 1'b1);
    endtask

    task automatic test_out_of_range();
        int         idx_tab[3]  = '{6, 7, 5};
        logic [5:0] want_tab[3] = '{6'b000000, 6'b000000, 6'b100000};
        logic       err_tab[3]  = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, idx_tab[i], 1'b1, 1'b1);
            if ({ov_c, act_c, err_c} !== {1'b1, want_tab[i], err_tab[i]}) begin
                errors++;
                $display("FAIL range idx=%0d got act=%b err=%b want act=%b err=%b",
                         idx_tab[i], act_c, err_c, want_tab[i], err_tab[i]);
            end
            checks++;
        end
        tick(1'b0, 0, 1'b1, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [7:0] want_seq[3] = '{8'h04, 8'h10, 8'h02};
        tick(1'b1, 2, 1'b0, 1'b1);
        if ({rdy_a, ov_a, act_a} !== {1'b1, 1'b1, 8'h04}) begin
            errors++;
            $display("FAIL bp_first got rdy=%b ov=%b act=%b want rdy=1 ov=1 act=00000100",
                     rdy_a, ov_a, act_a);
        end
        checks++;
        tick(1'b1, 4, 1'b0, 1'b1);
        if ({rdy_a, act_a} !== {1'b0, 8'h04}) begin
            errors++;
            $display("FAIL bp_full got rdy=%b act=%b want rdy=0 act=00000100", rdy_a, act_a);
        end
        checks++;
        tick(1'b1, 1, 1'b0, 1'b1);
        if ({rdy_a, act_a} !== {1'b0, 8'h04}) begin
            errors++;
            $display("FAIL bp_hold got rdy=%b act=%b want rdy=0 act=00000100", rdy_a, act_a);
        end
        checks++;
        for (int j = 0; j < 3; j++) begin
            if ({ov_a, act_a} !== {1'b1, want_seq[j]}) begin
                errors++;
                $display("FAIL bp_order pos=%0d got ov=%b act=%b want ov=1 act=%b",
                         j, ov_a, act_a, want_seq[j]);
            end
            checks++;
            tick((j < 2) ? 1'b1 : 1'b0, 1, 1'b1, 1'b1);
        end
        if (ov_a !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty got ov=%b want ov=0", ov_a);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 3, 1'b0, 1'b1);
        tick(1'b1, 6, 1'b0, 1'b1);
        if ({rdy_a, ov_a} !== 2'b01) begin
            errors++;
            $display("FAIL mid_full got rdy=%b ov=%b want rdy=0 ov=1", rdy_a, ov_a);
        end
        checks++;
        tick(1'b1, 5, 1'b1, 1'b0);
        if (obs_all !== RESET_VEC) begin
            errors++;
            $display("FAIL mid_reset got=%b want=%b", obs_all, RESET_VEC);
        end
        checks++;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 0, 1'b1, 1'b1);
            if ({ov_a, ov_b, ov_c} !== 3'b000) begin
                errors++;
                $display("FAIL mid_ghost cycle=%0d got ov=%b%b%b want ov=000", i, ov_a, ov_b, ov_c);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        logic        v, ordy, hold;
        int          idx;
        logic [26:0] saved;
        logic [30:0] want;
        tick(1'b0, 0, 1'b1, 1'b0);
        for (int cyc = 0; cyc < 10000; cyc++) begin
            v     = 1'($urandom_range(0, 1));
            ordy  = 1'($urandom_range(0, 1));
            idx   = int'($urandom_range(0, 7));
            hold  = ov_a && !ordy;
            saved = obs_data;
            tick(v, idx, ordy, 1'b1);
            if (hold) begin
                if (obs_data !== saved) begin
                    errors++;
                    $display("FAIL rand_stable cycle=%0d got=%h want=%h", cyc, obs_data, saved);
                end
                checks++;
            end
            want = model_vec();
            if (obs_all !== want) begin
                errors++;
                $display("FAIL rand_model cycle=%0d got=%b want=%b", cyc, obs_all, want);
            end
            checks++;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        index     = 3'd0;
        out_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_thermo();
        test_out_of_range();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
